dmem_console_bridge: RTL

- Sits between the core data-memory write port and the data RAM.
- Intercepts writes to the console (PUTC) and exit (EXIT) addresses and buffers console bytes in a FIFO. The bytes drain through a valid/ready character stream.
- Sequences program termination: the FIFO drains first, then `done` asserts.
- All other writes pass through to the RAM unchanged.

---
 rtl/dmem_console_bridge.sv | 86 ++++++++
 1 files changed

// File: rtl/dmem_console_bridge.sv
// dmem_console_bridge: routes core data writes to RAM, a console byte FIFO, or the exit/drain sequencer
module dmem_console_bridge #(
  parameter logic [31:0] PUTC_ADDR  = 32'h8000001c,
  parameter logic [31:0] EXIT_ADDR  = 32'h8000002c,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          core_wready,
  input  logic [31:0]                   core_waddr,
  input  logic [31:0]                   core_wdata,
  input  logic [3:0]                    core_wstrb,
  output logic                          core_wvalid,
  output logic                          mem_wready,
  input  logic                          mem_wvalid,
  output logic [31:0]                   mem_waddr,
  output logic [31:0]                   mem_wdata,
  output logic [3:0]                    mem_wstrb,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   exit_code,
  output logic                          done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          is_putc, is_exit, is_mem, run, full, empty, push, pop;
  assign is_putc     = core_wready & (core_waddr == PUTC_ADDR);
  assign is_exit     = core_wready & (core_waddr == EXIT_ADDR);
  assign is_mem      = core_wready & !is_putc & !is_exit;
  assign run         = state == RUN;
  assign full        = level == LW'(FIFO_DEPTH);
  assign empty       = level == '0;
  assign push        = is_putc & run & !full;
  assign pop         = tx_valid & tx_ready;
  assign mem_wready  = is_mem & run;
  assign mem_waddr   = core_waddr;
  assign mem_wdata   = core_wdata;
  assign mem_wstrb   = core_wstrb;
  assign core_wvalid = is_mem ? mem_wvalid & run : is_putc ? run & !full : is_exit & run;
  assign tx_valid    = !empty;
  assign tx_data     = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign fifo_level  = level;
  // Console byte storage; lane 0 only, strobes ignored
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_wdata[7:0];
  end
  // FIFO pointers and occupancy; full test uses pre-pop level
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
  // Run / drain / done sequencer with registered exit_code and done
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= RUN;
      exit_code <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        RUN: if (is_exit) begin
          exit_code <= core_wdata;
          state     <= DRAIN;
        end
        DRAIN: if (empty || (level == LW'(1) && pop)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end
endmodule
